// File: rtl/vram_arbiter_pkg.sv
// Shared display/framebuffer constants and the arbiter state encoding.
// The 640-pixel mode fetches 40 sixteen-pixel words per line from a 128K-word framebuffer.
package vram_arbiter_pkg;

   localparam int unsigned VRAM_ADDRW       = 17;
   localparam int unsigned VRAM_DATAW       = 16;
   localparam int unsigned DISPLAY_MODE_640 = 0;
   localparam int unsigned LINE_WORDS_640   = 40;
   localparam int unsigned VRAM_FAIR        = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

   // Bits needed to hold the values 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 32'd2) ? 32'd1 : $clog2(max_val + 32'd1);
   endfunction

endpackage

// File: rtl/vram_arbiter_rd_pipe.sv
// Two-stage read-return tag pipeline: follows each read grant to the cycle its
// BRAM data returns and routes mem_rdata to the display or drawing side.
module vram_rd_pipe #(
   parameter int unsigned DATAW = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rd_valid_i,
   input  logic             rd_disp_i,
   input  logic [DATAW-1:0] mem_rdata_i,
   output logic [DATAW-1:0] disp_data_o,
   output logic             disp_valid_o,
   output logic [DATAW-1:0] draw_rdata_o,
   output logic             draw_rvalid_o
);

   logic [1:0] valid_q;
   logic [1:0] disp_q;
   logic       disp_hit_s;
   logic       draw_hit_s;

   // Bit 0 is the cycle mem_* is presented, bit 1 the cycle mem_rdata is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 2'b00;
         disp_q  <= 2'b00;
      end else begin
         valid_q <= {valid_q[0], rd_valid_i};
         disp_q  <= {disp_q[0], rd_disp_i};
      end
   end

   // Demux the returning word; the idle side is held at zero.
   always_comb begin
      disp_hit_s   = valid_q[1] & disp_q[1];
      draw_hit_s   = valid_q[1] & ~disp_q[1];
      disp_data_o  = {DATAW{1'b0}};
      draw_rdata_o = {DATAW{1'b0}};
      if (disp_hit_s) begin
         disp_data_o = mem_rdata_i;
      end else if (draw_hit_s) begin
         draw_rdata_o = mem_rdata_i;
      end else begin
         disp_data_o  = {DATAW{1'b0}};
         draw_rdata_o = {DATAW{1'b0}};
      end
      disp_valid_o  = disp_hit_s;
      draw_rvalid_o = draw_hit_s;
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: line-burst display fetches with priority, drawing
// accesses in spare cycles, plus a fairness slot every FAIR display grants.
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int unsigned ADDRW      = VRAM_ADDRW,
   parameter int unsigned DATAW      = VRAM_DATAW,
   parameter int unsigned LINE_WORDS = LINE_WORDS_640,
   parameter int unsigned FAIR       = VRAM_FAIR
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             line_start,
   input  logic [ADDRW-1:0] line_addr,
   output logic [DATAW-1:0] disp_data,
   output logic             disp_valid,
   output logic             disp_overrun,
   input  logic             draw_req,
   input  logic             draw_we,
   input  logic [ADDRW-1:0] draw_addr,
   input  logic [DATAW-1:0] draw_wdata,
   output logic             draw_ack,
   output logic [DATAW-1:0] draw_rdata,
   output logic             draw_rvalid,
   output logic             busy,
   output logic [ADDRW-1:0] mem_addr,
   output logic             mem_we,
   output logic [DATAW-1:0] mem_wdata,
   input  logic [DATAW-1:0] mem_rdata
);

   localparam int unsigned   RW           = cnt_width(LINE_WORDS);
   localparam int unsigned   FW           = cnt_width(FAIR);
   localparam logic [RW-1:0] LINE_WORDS_C = RW'(LINE_WORDS);
   localparam logic [FW-1:0] FAIR_C       = FW'(FAIR);

   arb_state_t       state_q,     state_d;
   logic [ADDRW-1:0] ptr_q,       ptr_d;
   logic [RW-1:0]    rem_q,       rem_d;
   logic [FW-1:0]    fair_q,      fair_d;
   logic             overrun_q,   overrun_d;
   logic [ADDRW-1:0] mem_addr_q,  mem_addr_d;
   logic             mem_we_q,    mem_we_d;
   logic [DATAW-1:0] mem_wdata_q, mem_wdata_d;
   logic             disp_gnt_s;
   logic             draw_gnt_s;
   logic             rd_valid_s;

   // Grant decision, burst bookkeeping and next BRAM command.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      fair_d      = fair_q;
      overrun_d   = 1'b0;
      disp_gnt_s  = 1'b0;
      draw_gnt_s  = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         ST_IDLE: begin
            draw_gnt_s = draw_req;
            if (line_start) begin
               state_d = ST_BURST;
               ptr_d   = line_addr;
               rem_d   = LINE_WORDS_C;
               fair_d  = {FW{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BURST: begin
            overrun_d = line_start;
            if (draw_req && (fair_q == FAIR_C)) begin
               draw_gnt_s = 1'b1;
               fair_d     = {FW{1'b0}};
            end else begin
               disp_gnt_s = 1'b1;
               ptr_d      = ptr_q + ADDRW'(1);
               rem_d      = rem_q - RW'(1);
               fair_d     = (fair_q == FAIR_C) ? fair_q : (fair_q + FW'(1));
               state_d    = (rem_q == RW'(1)) ? ST_IDLE : ST_BURST;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // The BRAM command for the winner is presented one cycle after the grant.
      if (disp_gnt_s) begin
         mem_addr_d = ptr_q;
         mem_we_d   = 1'b0;
      end else if (draw_gnt_s) begin
         mem_addr_d  = draw_addr;
         mem_we_d    = draw_we;
         mem_wdata_d = draw_wdata;
      end else begin
         mem_addr_d = mem_addr_q;
         mem_we_d   = 1'b0;
      end
      rd_valid_s = disp_gnt_s | (draw_gnt_s & ~draw_we);
   end

   // Arbiter state and registered BRAM command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= {ADDRW{1'b0}};
         rem_q       <= {RW{1'b0}};
         fair_q      <= {FW{1'b0}};
         overrun_q   <= 1'b0;
         mem_addr_q  <= {ADDRW{1'b0}};
         mem_we_q    <= 1'b0;
         mem_wdata_q <= {DATAW{1'b0}};
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         fair_q      <= fair_d;
         overrun_q   <= overrun_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   vram_rd_pipe #(
      .DATAW (DATAW)
   ) u_rd_pipe (
      .clk           (clk),
      .rst_n         (rst_n),
      .rd_valid_i    (rd_valid_s),
      .rd_disp_i     (disp_gnt_s),
      .mem_rdata_i   (mem_rdata),
      .disp_data_o   (disp_data),
      .disp_valid_o  (disp_valid),
      .draw_rdata_o  (draw_rdata),
      .draw_rvalid_o (draw_rvalid)
   );

   assign draw_ack     = draw_gnt_s;
   assign busy         = (state_q == ST_BURST);
   assign disp_overrun = overrun_q;
   assign mem_addr     = mem_addr_q;
   assign mem_we       = mem_we_q;
   assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: BRAM model plus a transaction-level reference
// (word lists, shadow memory, pending-return queue) checked every cycle.
module tb_vram_arbiter;

   localparam int ADDRW      = 17;
   localparam int DATAW      = 16;
   localparam int LINE_WORDS = 40;
   localparam int FAIR       = 8;
   localparam int MEMSZ      = 1 << ADDRW;

   logic             clk;
   logic             rst_n;
   logic             line_start;
   logic [ADDRW-1:0] line_addr;
   logic [DATAW-1:0] disp_data;
   logic             disp_valid;
   logic             disp_overrun;
   logic             draw_req;
   logic             draw_we;
   logic [ADDRW-1:0] draw_addr;
   logic [DATAW-1:0] draw_wdata;
   logic             draw_ack;
   logic [DATAW-1:0] draw_rdata;
   logic             draw_rvalid;
   logic             busy;
   logic [ADDRW-1:0] mem_addr;
   logic             mem_we;
   logic [DATAW-1:0] mem_wdata;
   logic [DATAW-1:0] mem_rdata;

   vram_arbiter #(
      .ADDRW(ADDRW), .DATAW(DATAW), .LINE_WORDS(LINE_WORDS), .FAIR(FAIR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_addr(line_addr),
      .disp_data(disp_data), .disp_valid(disp_valid), .disp_overrun(disp_overrun),
      .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr),
      .draw_wdata(draw_wdata), .draw_ack(draw_ack), .draw_rdata(draw_rdata),
      .draw_rvalid(draw_rvalid), .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous BRAM, one-cycle read latency.
   logic [DATAW-1:0] ram [0:MEMSZ-1];
   always @(posedge clk) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
   end

   typedef struct {
      int          due;
      bit          disp;
      logic [15:0] data;
   } rd_t;

   logic [DATAW-1:0] shadow [0:MEMSZ-1];
   rd_t pend_q[$];
   bit  m_busy;
   int  m_left;
   int  m_addr;
   int  m_fair;
   bit  m_ovr;
   int  cyc;
   int  n_vec;
   int  n_err;
   int  g_words, g_busy, g_ovr, g_grants, g_rv;
   logic [15:0] g_first, g_last;
   bit  g_acked;
   int  g_ack_pos[$];

   task automatic clear_stats();
      g_words = 0; g_busy = 0; g_ovr = 0; g_grants = 0; g_rv = 0;
      g_first = 16'h0000; g_last = 16'h0000; g_acked = 1'b0;
      g_ack_pos.delete();
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_left = 0; m_addr = 0; m_fair = 0; m_ovr = 1'b0;
      pend_q.delete();
   endtask

   // One clock: called at posedge+1 with inputs already driven.
   task automatic step();
      bit dg, pg, exp_dv, exp_rv, was_busy;
      logic [15:0] exp_dd, exp_rd;
      rd_t e;
      #1;
      dg = draw_req && (!m_busy || m_fair == FAIR);
      pg = m_busy && !dg;
      exp_dv = 1'b0; exp_rv = 1'b0; exp_dd = 16'h0000; exp_rd = 16'h0000;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
         e = pend_q.pop_front();
         if (e.disp) begin exp_dv = 1'b1; exp_dd = e.data; end
         else begin exp_rv = 1'b1; exp_rd = e.data; end
      end
      n_vec++;
      if (draw_ack !== dg) begin n_err++; $display("FAIL draw_ack cyc %0d: got %b want %b", cyc, draw_ack, dg); end
      n_vec++;
      if (busy !== m_busy) begin n_err++; $display("FAIL busy cyc %0d: got %b want %b", cyc, busy, m_busy); end
      n_vec++;
      if (disp_overrun !== m_ovr) begin n_err++; $display("FAIL disp_overrun cyc %0d: got %b want %b", cyc, disp_overrun, m_ovr); end
      n_vec++;
      if (disp_valid !== exp_dv) begin n_err++; $display("FAIL disp_valid cyc %0d: got %b want %b", cyc, disp_valid, exp_dv); end
      n_vec++;
      if (draw_rvalid !== exp_rv) begin n_err++; $display("FAIL draw_rvalid cyc %0d: got %b want %b", cyc, draw_rvalid, exp_rv); end
      if (exp_dv) begin
         n_vec++;
         if (disp_data !== exp_dd) begin n_err++; $display("FAIL disp_data cyc %0d: got %h want %h", cyc, disp_data, exp_dd); end
      end
      if (exp_rv) begin
         n_vec++;
         if (draw_rdata !== exp_rd) begin n_err++; $display("FAIL draw_rdata cyc %0d: got %h want %h", cyc, draw_rdata, exp_rd); end
      end
      if (disp_valid === 1'b1) begin
         if (g_words == 0) g_first = disp_data;
         g_last = disp_data;
         g_words++;
      end
      if (draw_rvalid === 1'b1) g_rv++;
      if (busy === 1'b1) g_busy++;
      if (disp_overrun === 1'b1) g_ovr++;
      g_acked = (draw_ack === 1'b1);
      if (draw_ack === 1'b1 && busy === 1'b1) g_ack_pos.push_back(g_grants);
      was_busy = m_busy;
      m_ovr = was_busy && line_start;
      if (dg) begin
         if (draw_we) shadow[int'(draw_addr)] = draw_wdata;
         else begin
            e.due = cyc + 2; e.disp = 1'b0; e.data = shadow[int'(draw_addr)];
            pend_q.push_back(e);
         end
         if (was_busy) m_fair = 0;
      end
      if (pg) begin
         e.due = cyc + 2; e.disp = 1'b1; e.data = shadow[m_addr];
         pend_q.push_back(e);
         m_addr = (m_addr + 1) % MEMSZ;
         m_left--;
         g_grants++;
         if (m_fair < FAIR) m_fair++;
         if (m_left == 0) m_busy = 1'b0;
      end
      if (!was_busy && line_start) begin
         m_busy = 1'b1; m_addr = int'(line_addr); m_left = LINE_WORDS; m_fair = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic finish_burst(input string name);
      int k;
      k = 0;
      while (m_busy && k < 200) begin step(); k++; end
      n_vec++;
      if (k >= 200) begin n_err++; $display("FAIL %s timeout: got %0d cycles want <200", name, k); end
      repeat (3) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; line_start = 1'b0; line_addr = '0; draw_req = 1'b0;
      draw_we = 1'b0; draw_addr = '0; draw_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({disp_valid, draw_rvalid, disp_overrun, busy, draw_ack, mem_we} !== 6'b000000) begin
         n_err++; $display("FAIL reset_flags: got %b want 000000", {disp_valid, draw_rvalid, disp_overrun, busy, draw_ack, mem_we});
      end
      n_vec++;
      if ({mem_addr, mem_wdata, disp_data, draw_rdata} !== 65'd0) begin
         n_err++; $display("FAIL reset_buses: got %h want 0", {mem_addr, mem_wdata, disp_data, draw_rdata});
      end
      rst_n = 1'b1;
      model_reset();
      cyc = 0;
   endtask

   task automatic test_idle_draw();
      clear_stats();
      draw_req = 1'b1; draw_we = 1'b1; draw_addr = 17'h00010; draw_wdata = 16'h1234;
      step();
      n_vec++;
      if (!g_acked) begin n_err++; $display("FAIL idle_write_ack: got 0 want 1"); end
      draw_we = 1'b0; draw_wdata = 16'h0000;
      step();
      n_vec++;
      if (!g_acked) begin n_err++; $display("FAIL idle_read_ack: got 0 want 1"); end
      draw_req = 1'b0;
      step();
      #1;
      n_vec++;
      if (draw_rvalid !== 1'b1 || draw_rdata !== 16'h1234) begin
         n_err++; $display("FAIL idle_read_data: got v=%b d=%h want v=1 d=1234", draw_rvalid, draw_rdata);
      end
      #1;
      repeat (2) step();
   endtask

   task automatic test_clean_burst();
      clear_stats();
      line_start = 1'b1; line_addr = 17'h00100;
      step();
      line_start = 1'b0;
      finish_burst("clean");
      n_vec++;
      if (g_words != LINE_WORDS) begin n_err++; $display("FAIL clean_words: got %0d want 40", g_words); end
      n_vec++;
      if (g_busy != LINE_WORDS) begin n_err++; $display("FAIL clean_busy: got %0d want 40", g_busy); end
      n_vec++;
      if (g_first !== 16'h0100 || g_last !== 16'h0127) begin
         n_err++; $display("FAIL clean_ends: got %h..%h want 0100..0127", g_first, g_last);
      end
   endtask

   task automatic test_fairness();
      int k;
      clear_stats();
      line_start = 1'b1; line_addr = 17'h00200;
      step();
      line_start = 1'b0;
      draw_req = 1'b1; draw_we = 1'b0; draw_addr = 17'($urandom_range(0, 1023));
      k = 0;
      while (m_busy && k < 200) begin
         step();
         if (g_acked) draw_addr = 17'($urandom_range(0, 1023));
         k++;
      end
      draw_req = 1'b0;
      repeat (3) step();
      n_vec++;
      if (g_busy != 44) begin n_err++; $display("FAIL fair_busy: got %0d want 44", g_busy); end
      n_vec++;
      if (g_words != LINE_WORDS || g_first !== 16'h0200 || g_last !== 16'h0227) begin
         n_err++; $display("FAIL fair_words: got %0d %h..%h want 40 0200..0227", g_words, g_first, g_last);
      end
      n_vec++;
      if (g_ack_pos.size() != 4) begin
         n_err++; $display("FAIL fair_ack_count: got %0d want 4", g_ack_pos.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (g_ack_pos[i] != (i + 1) * FAIR) begin
               n_err++; $display("FAIL fair_ack_pos%0d: got %0d want %0d", i, g_ack_pos[i], (i + 1) * FAIR);
            end
         end
      end
   endtask

   task automatic test_overrun_wrap();
      int k;
      clear_stats();
      line_start = 1'b1; line_addr = 17'h1FFEC;
      step();
      line_start = 1'b0;
      k = 0;
      while (m_busy && k < 200) begin
         line_start = (k == 10); line_addr = 17'h00000;
         step();
         k++;
      end
      line_start = 1'b0;
      repeat (3) step();
      n_vec++;
      if (g_ovr != 1) begin n_err++; $display("FAIL wrap_overrun: got %0d want 1", g_ovr); end
      n_vec++;
      if (g_words != LINE_WORDS) begin n_err++; $display("FAIL wrap_words: got %0d want 40", g_words); end
      n_vec++;
      if (g_first !== 16'hFFEC || g_last !== 16'h0013) begin
         n_err++; $display("FAIL wrap_ends: got %h..%h want ffec..0013", g_first, g_last);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      clear_stats();
      line_start = 1'b1; line_addr = 17'h00400;
      step();
      line_start = 1'b0;
      k = 0;
      while (g_grants < 15 && k < 100) begin step(); k++; end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({disp_valid, draw_rvalid, disp_overrun, busy, draw_ack, mem_we} !== 6'b000000) begin
         n_err++; $display("FAIL midrst_flags: got %b want 000000", {disp_valid, draw_rvalid, disp_overrun, busy, draw_ack, mem_we});
      end
      n_vec++;
      if ({mem_addr, mem_wdata, disp_data, draw_rdata} !== 65'd0) begin
         n_err++; $display("FAIL midrst_buses: got %h want 0", {mem_addr, mem_wdata, disp_data, draw_rdata});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      cyc++;
      clear_stats();
      repeat (6) step();
      n_vec++;
      if (g_words != 0 || g_rv != 0) begin n_err++; $display("FAIL midrst_stale: got %0d/%0d want 0/0", g_words, g_rv); end
      line_start = 1'b1; line_addr = 17'h00500;
      step();
      line_start = 1'b0;
      finish_burst("post_reset");
      n_vec++;
      if (g_words != LINE_WORDS || g_first !== 16'h0500 || g_last !== 16'h0527) begin
         n_err++; $display("FAIL midrst_new_burst: got %0d %h..%h want 40 0500..0527", g_words, g_first, g_last);
      end
   endtask

   task automatic test_random();
      int exp_ovr;
      clear_stats();
      exp_ovr = 0;
      for (int i = 0; i < 1500; i++) begin
         line_start = ($urandom_range(0, 39) == 0);
         line_addr = 17'($urandom);
         if (!draw_req || g_acked) begin
            draw_req   = ($urandom_range(0, 2) != 0);
            draw_we    = 1'($urandom_range(0, 1));
            draw_addr  = 17'($urandom_range(0, 63));
            draw_wdata = 16'($urandom);
         end
         if (m_busy && line_start) exp_ovr++;
         step();
      end
      line_start = 1'b0; draw_req = 1'b0;
      finish_burst("random");
      n_vec++;
      if (g_ovr != exp_ovr) begin n_err++; $display("FAIL random_overruns: got %0d want %0d", g_ovr, exp_ovr); end
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      for (int i = 0; i < MEMSZ; i++) begin
         ram[i] = 16'(i);
         shadow[i] = 16'(i);
      end
      model_reset();
      clear_stats();
      test_reset();
      test_idle_draw();
      test_clean_burst();
      test_fairness();
      test_overrun_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
